pcmcia_host_cycle: RTL and testbench

Host-side bus cycle generator for the card register/memory interface: turns single-beat read/write requests from the controller core into properly timed REGSELB/CE1B/OEB/WEB strobe sequences on the card bus and returns read data. It is the initiator counterpart of the card's configuration-register responder and is used to program and read back the configuration option register (attribute space, A[9]=1) before common-memory traffic is enabled.

---
 rtl/pcmcia_host_pkg.sv | 30 +++
 rtl/pcmcia_host_cycle_cdc_sync2.sv | 27 ++
 rtl/pcmcia_host_cycle.sv | 249 ++++++++++++++++++++++++
 tb/tb_pcmcia_host_cycle.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcmcia_host_pkg.sv
// Shared types and constants for the PCMCIA host bus-cycle generator.
package pcmcia_host_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned DEF_SETUP_CYC    = 2;
  localparam int unsigned DEF_STROBE_CYC   = 6;
  localparam int unsigned DEF_HOLD_CYC     = 2;
  localparam int unsigned DEF_WAIT_TIMEOUT = 255;

  // Configuration option register in attribute space (A[9]=1).
  localparam logic [ADDR_W-1:0] CONF_REG_ADDR = 16'h0200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Phase counters load n-1 and expire at zero, giving exactly n cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pcmcia_host_cycle_cdc_sync2.sv
// Two-flop synchronizer for the asynchronous WAITB input; idles high (no wait).
module cdc_sync2
  import pcmcia_host_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to the inactive (high) level so a reset never looks like a wait request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pcmcia_host_cycle.sv
// Host-side card bus cycle generator: turns single-beat requests into timed
// REGSELB/CE1B/OEB/WEB strobe sequences and returns read data.
// Optional feature macro: PCMCIA_HOST_WAIT_EN (honour WAITB, WAIT state, timeout).
module pcmcia_host_cycle
  import pcmcia_host_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC   = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_attr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D_out,
  input  logic [DATA_W-1:0] D_in,
  output logic              D_oe,
  output logic              REGSELB,
  output logic              CE1B,
  output logic              OEB,
  output logic              WEB,
  input  logic              WAITB
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = cnt_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LOAD = cnt_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = cnt_load(HOLD_CYC);
  localparam logic [CNT_W-1:0] WAIT_LOAD   = cnt_load(WAIT_TIMEOUT);

  state_t              r_state,       w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,         w_cnt_nxt;
  logic                r_write,       w_write_nxt;
  logic [DATA_W-1:0]   r_rdata,       w_rdata_nxt;
  logic                r_timeout,     w_timeout_nxt;
  logic                r_req_ready,   w_req_ready_nxt;
  logic [ADDR_W-1:0]   r_a,           w_a_nxt;
  logic [DATA_W-1:0]   r_dout,        w_dout_nxt;
  logic                r_doe,         w_doe_nxt;
  logic                r_regselb,     w_regselb_nxt;
  logic                r_ce1b,        w_ce1b_nxt;
  logic                r_oeb,         w_oeb_nxt;
  logic                r_web,         w_web_nxt;
  logic                r_rsp_valid,   w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
  logic                r_rsp_timeout, w_rsp_timeout_nxt;

`ifdef PCMCIA_HOST_WAIT_EN
  logic w_waitb_s;

  cdc_sync2 u_waitb_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (WAITB),
    .o_q   (w_waitb_s)
  );
`else
  // WAITB and the wait budget have no effect in this build.
  logic [CNT_W:0] w_unused_wait;
  assign w_unused_wait = {WAITB, WAIT_LOAD};
`endif

  // State and registered bus/response outputs; reset releases every strobe at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_rdata       <= '0;
      r_timeout     <= 1'b0;
      r_req_ready   <= 1'b0;
      r_a           <= '0;
      r_dout        <= '0;
      r_doe         <= 1'b0;
      r_regselb     <= 1'b1;
      r_ce1b        <= 1'b1;
      r_oeb         <= 1'b1;
      r_web         <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_write       <= w_write_nxt;
      r_rdata       <= w_rdata_nxt;
      r_timeout     <= w_timeout_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_a           <= w_a_nxt;
      r_dout        <= w_dout_nxt;
      r_doe         <= w_doe_nxt;
      r_regselb     <= w_regselb_nxt;
      r_ce1b        <= w_ce1b_nxt;
      r_oeb         <= w_oeb_nxt;
      r_web         <= w_web_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  // Next state and next-cycle bus values; strobes default high, bus fields default hold.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_write_nxt       = r_write;
    w_rdata_nxt       = r_rdata;
    w_timeout_nxt     = r_timeout;
    w_req_ready_nxt   = 1'b0;
    w_a_nxt           = r_a;
    w_dout_nxt        = r_dout;
    w_doe_nxt         = r_doe;
    w_regselb_nxt     = r_regselb;
    w_ce1b_nxt        = r_ce1b;
    w_oeb_nxt         = 1'b1;
    w_web_nxt         = 1'b1;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_rdata_nxt   = '0;
    w_rsp_timeout_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_state_nxt     = ST_SETUP;
          w_cnt_nxt       = SETUP_LOAD;
          w_write_nxt     = req_write;
          w_rdata_nxt     = '0;
          w_timeout_nxt   = 1'b0;
          w_req_ready_nxt = 1'b0;
          w_a_nxt         = req_addr;
          w_dout_nxt      = req_wdata;
          w_doe_nxt       = req_write;
          w_regselb_nxt   = ~req_attr;
          w_ce1b_nxt      = 1'b0;
        end
      end

      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = STROBE_LOAD;
          w_oeb_nxt   = r_write;
          w_web_nxt   = ~r_write;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_STROBE: begin
        w_oeb_nxt = r_write;
        w_web_nxt = ~r_write;
        if (r_cnt == '0) begin
`ifdef PCMCIA_HOST_WAIT_EN
          if (!w_waitb_s) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end else begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = HOLD_LOAD;
            w_oeb_nxt   = 1'b1;
            w_web_nxt   = 1'b1;
            w_rdata_nxt = r_write ? '0 : D_in;
          end
`else
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
          w_oeb_nxt   = 1'b1;
          w_web_nxt   = 1'b1;
          w_rdata_nxt = r_write ? '0 : D_in;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_WAIT: begin
`ifdef PCMCIA_HOST_WAIT_EN
        w_oeb_nxt = r_write;
        w_web_nxt = ~r_write;
        if (w_waitb_s) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
          w_oeb_nxt   = 1'b1;
          w_web_nxt   = 1'b1;
          w_rdata_nxt = r_write ? '0 : D_in;
        end else if (r_cnt == '0) begin
          // Card never released WAITB: abandon the strobe and flag it.
          w_state_nxt   = ST_HOLD;
          w_cnt_nxt     = HOLD_LOAD;
          w_oeb_nxt     = 1'b1;
          w_web_nxt     = 1'b1;
          w_rdata_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
`else
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = HOLD_LOAD;
`endif
      end

      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt       = ST_DONE;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = r_rdata;
          w_rsp_timeout_nxt = r_timeout;
          w_ce1b_nxt        = 1'b1;
          w_regselb_nxt     = 1'b1;
          w_doe_nxt         = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        w_state_nxt     = ST_IDLE;
        w_req_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign A           = r_a;
  assign D_out       = r_dout;
  assign D_oe        = r_doe;
  assign REGSELB     = r_regselb;
  assign CE1B        = r_ce1b;
  assign OEB         = r_oeb;
  assign WEB         = r_web;

endmodule

// File: tb/tb_pcmcia_host_cycle.sv
// Directed bench for pcmcia_host_cycle with a one-register card model.
module tb_pcmcia_host_cycle;
  import pcmcia_host_pkg::*;

  logic        clk, rst, card_rst, sel;
  logic        req_valid, req_write, req_attr, waitb;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, d_in;

  logic        req_ready1, rsp_valid1, rsp_timeout1, d_oe1, regselb1, ce1b1, oeb1, web1;
  logic [7:0]  rsp_rdata1, d_out1;
  logic [15:0] a1;

  logic        m_req_ready, m_rsp_valid, m_rsp_timeout, m_doe, m_regselb, m_ce1b, m_oeb, m_web;
  logic [7:0]  m_rsp_rdata, m_dout;
  logic [15:0] m_a;

  logic [7:0]  conf_reg;
  int          cyc = 0;
  int          acc_cyc;
  int          n_cmp = 0;
  int          n_err = 0;

  pcmcia_host_cycle u_dut (
    .CLK (clk), .RESET (rst),
    .req_valid (req_valid & ~sel), .req_ready (req_ready1),
    .req_write (req_write), .req_attr (req_attr), .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid1), .rsp_rdata (rsp_rdata1), .rsp_timeout (rsp_timeout1),
    .A (a1), .D_out (d_out1), .D_in (d_in), .D_oe (d_oe1),
    .REGSELB (regselb1), .CE1B (ce1b1), .OEB (oeb1), .WEB (web1), .WAITB (waitb)
  );

`ifdef PCMCIA_HOST_WAIT_EN
  logic        req_ready2, rsp_valid2, rsp_timeout2, d_oe2, regselb2, ce1b2, oeb2, web2;
  logic [7:0]  rsp_rdata2, d_out2;
  logic [15:0] a2;

  pcmcia_host_cycle #(.WAIT_TIMEOUT(4)) u_dut_to (
    .CLK (clk), .RESET (rst),
    .req_valid (req_valid & sel), .req_ready (req_ready2),
    .req_write (req_write), .req_attr (req_attr), .req_addr (req_addr), .req_wdata (req_wdata),
    .rsp_valid (rsp_valid2), .rsp_rdata (rsp_rdata2), .rsp_timeout (rsp_timeout2),
    .A (a2), .D_out (d_out2), .D_in (d_in), .D_oe (d_oe2),
    .REGSELB (regselb2), .CE1B (ce1b2), .OEB (oeb2), .WEB (web2), .WAITB (waitb)
  );

  assign m_req_ready   = sel ? req_ready2   : req_ready1;
  assign m_rsp_valid   = sel ? rsp_valid2   : rsp_valid1;
  assign m_rsp_rdata   = sel ? rsp_rdata2   : rsp_rdata1;
  assign m_rsp_timeout = sel ? rsp_timeout2 : rsp_timeout1;
  assign m_a           = sel ? a2           : a1;
  assign m_dout        = sel ? d_out2       : d_out1;
  assign m_doe         = sel ? d_oe2        : d_oe1;
  assign m_regselb     = sel ? regselb2     : regselb1;
  assign m_ce1b        = sel ? ce1b2        : ce1b1;
  assign m_oeb         = sel ? oeb2         : oeb1;
  assign m_web         = sel ? web2         : web1;
`else
  assign m_req_ready   = req_ready1;
  assign m_rsp_valid   = rsp_valid1;
  assign m_rsp_rdata   = rsp_rdata1;
  assign m_rsp_timeout = rsp_timeout1;
  assign m_a           = a1;
  assign m_dout        = d_out1;
  assign m_doe         = d_oe1;
  assign m_regselb     = regselb1;
  assign m_ce1b        = ce1b1;
  assign m_oeb         = oeb1;
  assign m_web         = web1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Card model: config register latched on WEB rising; common memory data valid once WAITB is high.
  always @(posedge m_web or posedge card_rst) begin
    if (card_rst) conf_reg <= 8'h00;
    else if (!rst && !m_ce1b && !m_regselb && m_a == CONF_REG_ADDR) conf_reg <= m_dout;
  end

  assign d_in = (!m_regselb && m_a == CONF_REG_ADDR) ? conf_reg : (waitb ? 8'h3C : 8'hEE);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for req_ready, confirm the bus is idle, then step past the accepting edge.
  task automatic wait_accept(input string tag, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      check({tag, ".idle"}, 32'({m_ce1b, m_regselb, m_oeb, m_web, m_doe, m_rsp_valid}), 32'h3C);
      @(posedge clk);
      #1;
    end else begin
      check({tag, ".accept"}, 32'(ok), 32'd1);
    end
  endtask

  task automatic do_xfer(input string tag, input logic wr, input logic attr,
                         input logic [15:0] addr, input logic [7:0] wdata, input logic keep,
                         input int rel, input int exp_len, input int exp_rsp,
                         input logic [7:0] exp_rdata, input logic exp_tout);
    int c, fall, lown, viol, rsp_c;
    logic ok, got, regsel_s, doe_s, tout_s;
    logic [7:0] dout_s, rdata_s;
    req_write = wr; req_attr = attr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wait_accept(tag, ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (!keep) req_valid = 1'b0;
    c = 0; fall = -1; lown = 0; viol = 0; rsp_c = -1; got = 1'b0;
    regsel_s = 1'b1; doe_s = 1'b0; dout_s = 8'h00; rdata_s = 8'h00; tout_s = 1'b0;
    while (!got && c < 60) begin
      if (!m_oeb || !m_web) begin
        if (fall < 0) fall = c;
        lown++;
        regsel_s = m_regselb; doe_s = m_doe; dout_s = m_dout;
      end
      if (!m_oeb && !m_web) viol++;
      if (!m_oeb && m_doe) viol++;
      if (c == rel) waitb = 1'b1;
      if (m_rsp_valid) begin
        got = 1'b1; rsp_c = c; rdata_s = m_rsp_rdata; tout_s = m_rsp_timeout;
      end else begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    check({tag, ".rsp"},     32'(got),      32'd1);
    check({tag, ".fall"},    32'(fall),     32'd2);
    check({tag, ".len"},     32'(lown),     32'(exp_len));
    check({tag, ".rsp_cyc"}, 32'(rsp_c),    32'(exp_rsp));
    check({tag, ".rdata"},   32'(rdata_s),  32'(exp_rdata));
    check({tag, ".tout"},    32'(tout_s),   32'(exp_tout));
    check({tag, ".viol"},    32'(viol),     32'd0);
    check({tag, ".regsel"},  32'(regsel_s), 32'(!attr));
    check({tag, ".doe"},     32'(doe_s),    32'(wr));
    if (wr) check({tag, ".dout"}, 32'(dout_s), 32'(wdata));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok, saw;
    int   first;
    clk = 1'b0; rst = 1'b1; card_rst = 1'b1; sel = 1'b0; waitb = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_attr = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;

    #12;
    check("reset.a",    32'({m_a, m_dout}), 32'h0);
    check("reset.ctl",  32'({m_doe, m_regselb, m_ce1b, m_oeb, m_web, m_rsp_valid, m_rsp_timeout, m_req_ready}), 32'h78);
    check("reset.rdat", 32'(m_rsp_rdata), 32'h0);
    card_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_reset", 32'(m_req_ready), 32'd1);

    do_xfer("wr_conf", 1'b1, 1'b1, 16'h0200, 8'h01, 1'b0, -1, 6, 10, 8'h00, 1'b0);
    check("card_configured", 32'(conf_reg[0]), 32'd1);
    do_xfer("rd_conf", 1'b0, 1'b1, 16'h0200, 8'h00, 1'b0, -1, 6, 10, 8'h01, 1'b0);

`ifdef PCMCIA_HOST_WAIT_EN
    waitb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_xfer("rd_wait", 1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, 10, 11, 15, 8'h3C, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b1; waitb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_xfer("rd_tmo", 1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, -1, 10, 14, 8'h00, 1'b1);
    waitb = 1'b1;
    repeat (2) @(posedge clk);
    #1 sel = 1'b0;
`else
    waitb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_xfer("rd_nowait", 1'b0, 1'b0, 16'h0010, 8'h00, 1'b0, -1, 6, 10, 8'hEE, 1'b0);
    waitb = 1'b1;
`endif

    req_write = 1'b1; req_attr = 1'b0; req_addr = 16'h0040; req_wdata = 8'h77; req_valid = 1'b1;
    wait_accept("rst_mid", ok);
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid.web_low", 32'(m_web), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid.bus", 32'({m_web, m_oeb, m_ce1b, m_regselb, m_doe, m_req_ready}), 32'h3C);
    saw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (m_rsp_valid) saw = 1'b1;
    end
    check("rst_mid.no_rsp", 32'(saw), 32'd0);
    @(posedge clk);
    #1;
    do_xfer("post_rst", 1'b1, 1'b0, 16'h0040, 8'h33, 1'b0, -1, 6, 10, 8'h00, 1'b0);

    do_xfer("b2b_1", 1'b1, 1'b0, 16'h0040, 8'h5A, 1'b1, -1, 6, 10, 8'h00, 1'b0);
    first = acc_cyc;
    do_xfer("b2b_2", 1'b0, 1'b0, 16'h0040, 8'h00, 1'b0, -1, 6, 10, 8'h3C, 1'b0);
    check("b2b.gap", 32'(acc_cyc - first), 32'd12);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
